// File: rtl/mpu_mem_pkg.sv
// Shared defaults, width helpers and egress state encoding for the MPU local-memory stream buffer.
package mpu_mem_pkg;

  localparam int CHUNK_BITS_DEFAULT = 512;
  localparam int DEPTH_DEFAULT      = 4;

  function automatic int bytes_of(input int chunk_bits);
    return chunk_bits / 8;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTES_DEFAULT    = bytes_of(CHUNK_BITS_DEFAULT);
  localparam int BYTE_CNT_W_DEF   = cnt_w(BYTES_DEFAULT);
  localparam int FIFO_PTR_W_DEF   = cnt_w(DEPTH_DEFAULT);
  localparam int FIFO_LVL_W_DEF   = $clog2(DEPTH_DEFAULT + 1);

  typedef enum logic {
    EG_IDLE = 1'b0,
    EG_SEND = 1'b1
  } egress_state_t;

endpackage

// File: rtl/chunk_fifo.sv
// DEPTH x CHUNK_BITS chunk FIFO; head reads as zero when empty, storage is never cleared.
module chunk_fifo
  import mpu_mem_pkg::*;
#(
  parameter int CHUNK_BITS = CHUNK_BITS_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [CHUNK_BITS-1:0]        push_data,
  input  logic                         pop,
  output logic [CHUNK_BITS-1:0]        head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [CHUNK_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full       = (count == LVL_W'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head       = empty ? '0 : mem[rd_ptr];
  assign fill_level = count;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/chunk_stream_buffer.sv
// Byte-serial host <-> wide chunk bridge: ingress packer + chunk FIFO, egress unpacker.
// Optional partial-chunk flush enabled by defining CHUNK_STREAM_FLUSH_EN.
module chunk_stream_buffer
  import mpu_mem_pkg::*;
#(
  parameter int CHUNK_BITS = CHUNK_BITS_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   host_in_data,
  input  logic                         host_in_valid,
  output logic                         host_in_ready,
  output logic [CHUNK_BITS-1:0]        chunk_out,
  output logic                         chunk_out_valid,
  input  logic                         chunk_out_ready,
  input  logic [CHUNK_BITS-1:0]        chunk_in,
  input  logic                         chunk_in_valid,
  output logic                         chunk_in_ready,
  output logic [7:0]                   host_out_data,
  output logic                         host_out_valid,
  input  logic                         host_out_ready,
`ifdef CHUNK_STREAM_FLUSH_EN
  input  logic                         host_flush,
  output logic                         host_flush_done,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int BYTES = bytes_of(CHUNK_BITS);
  localparam int CNT_W = cnt_w(BYTES);

  logic [CNT_W-1:0]      in_cnt;
  logic [7:0]            pack_buf [BYTES];
  logic [CHUNK_BITS-1:0] push_data;
  logic                  push;
  logic                  accept;
  logic                  last_in;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign last_in       = (in_cnt == CNT_W'(BYTES - 1));
  assign host_in_ready = !(last_in && fifo_full);
  assign accept        = host_in_valid && host_in_ready;

  // Slots beyond the current byte read as zero so a flushed partial chunk is zero-padded
  always_comb begin
    push_data = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (CNT_W'(k) < in_cnt)
        push_data[8*k +: 8] = pack_buf[k];
      else if (CNT_W'(k) == in_cnt && accept)
        push_data[8*k +: 8] = host_in_data;
    end
  end

`ifdef CHUNK_STREAM_FLUSH_EN
  logic pending;
  logic flush_push;

  assign pending         = (in_cnt != '0) || accept;
  assign flush_push      = host_flush && pending && !fifo_full;
  assign host_flush_done = host_flush && (!pending || !fifo_full);
  assign push            = (accept && last_in) || flush_push;
`else
  assign push = accept && last_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         in_cnt <= '0;
    else if (push)   in_cnt <= '0;
    else if (accept) in_cnt <= in_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) pack_buf[in_cnt] <= host_in_data;
  end

  chunk_fifo #(
    .CHUNK_BITS (CHUNK_BITS),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (chunk_out_ready),
    .head       (chunk_out),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .fill_level (fill_level)
  );

  assign chunk_out_valid = !fifo_empty;

  // Egress unpacker
  egress_state_t         state;
  egress_state_t         state_nxt;
  logic [CNT_W-1:0]      out_cnt;
  logic [CNT_W-1:0]      out_cnt_nxt;
  logic [CHUNK_BITS-1:0] egress_chunk;
  logic                  load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EG_IDLE;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      out_cnt <= out_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load) egress_chunk <= chunk_in;
  end

  always_comb begin
    state_nxt      = state;
    out_cnt_nxt    = out_cnt;
    load           = 1'b0;
    chunk_in_ready = 1'b0;
    host_out_valid = 1'b0;
    host_out_data  = '0;
    case (state)
      EG_IDLE: begin
        chunk_in_ready = 1'b1;
        if (chunk_in_valid) begin
          load        = 1'b1;
          out_cnt_nxt = '0;
          state_nxt   = EG_SEND;
        end
      end
      EG_SEND: begin
        host_out_valid = 1'b1;
        host_out_data  = egress_chunk[{out_cnt, 3'b000} +: 8];
        if (host_out_ready) begin
          if (out_cnt == CNT_W'(BYTES - 1)) begin
            out_cnt_nxt = '0;
            state_nxt   = EG_IDLE;
          end else begin
            out_cnt_nxt = out_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_chunk_stream_buffer.sv
// Bench for chunk_stream_buffer (32-bit chunks, 2-deep FIFO) against a queue-based reference model.
module tb_chunk_stream_buffer;

  localparam int CB = 32;
  localparam int DP = 2;
  localparam int NB = CB / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    host_in_data = '0;
  logic          host_in_valid = 1'b0;
  logic          host_in_ready;
  logic [CB-1:0] chunk_out;
  logic          chunk_out_valid;
  logic          chunk_out_ready = 1'b0;
  logic [CB-1:0] chunk_in = '0;
  logic          chunk_in_valid = 1'b0;
  logic          chunk_in_ready;
  logic [7:0]    host_out_data;
  logic          host_out_valid;
  logic          host_out_ready = 1'b0;
  logic [1:0]    fill_level;
`ifdef CHUNK_STREAM_FLUSH_EN
  logic          host_flush = 1'b0;
  logic          host_flush_done;
`endif

  always #5 clk = ~clk;

  chunk_stream_buffer #(.CHUNK_BITS(CB), .DEPTH(DP)) dut (
    .clk             (clk),
    .rst             (rst),
    .host_in_data    (host_in_data),
    .host_in_valid   (host_in_valid),
    .host_in_ready   (host_in_ready),
    .chunk_out       (chunk_out),
    .chunk_out_valid (chunk_out_valid),
    .chunk_out_ready (chunk_out_ready),
    .chunk_in        (chunk_in),
    .chunk_in_valid  (chunk_in_valid),
    .chunk_in_ready  (chunk_in_ready),
    .host_out_data   (host_out_data),
    .host_out_valid  (host_out_valid),
    .host_out_ready  (host_out_ready),
`ifdef CHUNK_STREAM_FLUSH_EN
    .host_flush      (host_flush),
    .host_flush_done (host_flush_done),
`endif
    .fill_level      (fill_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued chunks, bytes of the partial chunk, bytes still to be sent to the host
  logic [31:0] cq [$];
  logic [7:0]  part [$];
  logic [7:0]  eq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    part.delete();
    eq.delete();
  endtask

  task automatic check_all();
    chk("host_in_ready",   32'(host_in_ready),   32'(!(part.size() == NB-1 && cq.size() == DP)));
    chk("chunk_out_valid", 32'(chunk_out_valid), 32'(cq.size() > 0));
    chk("chunk_out",       chunk_out,            (cq.size() > 0) ? cq[0] : 32'h0);
    chk("fill_level",      32'(fill_level),      32'(cq.size()));
    chk("chunk_in_ready",  32'(chunk_in_ready),  32'(eq.size() == 0));
    chk("host_out_valid",  32'(host_out_valid),  32'(eq.size() > 0));
    chk("host_out_data",   32'(host_out_data),   (eq.size() > 0) ? 32'(eq[0]) : 32'h0);
  endtask

  task automatic cyc(input logic hv, input logic [7:0] hd, input logic cor,
                     input logic civ, input logic [31:0] ci, input logic hor);
    bit e_hir, e_cir, e_cov, e_hov;
    host_in_valid   = hv;
    host_in_data    = hd;
    chunk_out_ready = cor;
    chunk_in_valid  = civ;
    chunk_in        = ci;
    host_out_ready  = hor;
    e_hir = !(part.size() == NB-1 && cq.size() == DP);
    e_cir = (eq.size() == 0);
    e_cov = (cq.size() > 0);
    e_hov = (eq.size() > 0);
    @(posedge clk);
    if (e_cov && cor) void'(cq.pop_front());
    if (hv && e_hir) begin
      part.push_back(hd);
      if (part.size() == NB) begin
        cq.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end
    if (e_hov && hor) void'(eq.pop_front());
    if (e_cir && civ) for (int k = 0; k < NB; k++) eq.push_back(ci[8*k +: 8]);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;

    // Reset in the middle of packing discards the partial chunk
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 1'b0);
    host_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_fill", 32'(fill_level), 32'h0);
    chk("rst_hir", 32'(host_in_ready), 32'h1);
    #2 rst = 1'b0;
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_chunk", chunk_out, 32'hDDCCBBAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);

    // Basic packing and one-cycle latency
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_last_valid", 32'(chunk_out_valid), 32'h0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pack_chunk", chunk_out, 32'h44332211);
    chk("pack_valid", 32'(chunk_out_valid), 32'h1);
    chk("pack_fill", 32'(fill_level), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);

    // Full FIFO backpressure; a same-cycle pop does not release the last byte
    for (int i = 0; i < 2*NB + 3; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_hir", 32'(host_in_ready), 32'h0);
    cyc(1'b1, 8'h4B, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("pop_hir", 32'(host_in_ready), 32'h1);
    chk("pop_fill", 32'(fill_level), 32'h1);
    cyc(1'b1, 8'h4B, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("refill_fill", 32'(fill_level), 32'h2);
    chk("refill_head", chunk_out, 32'h47464544);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drained_fill", 32'(fill_level), 32'h0);

    // Egress with a host stall
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 32'hA1B2C3D4, 1'b0);
    chk("eg_d4", 32'(host_out_data), 32'hD4);
    chk("eg_busy", 32'(chunk_in_ready), 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678, 1'b1);
    chk("eg_c3", 32'(host_out_data), 32'hC3);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("eg_c3_hold", 32'(host_out_data), 32'hC3);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("eg_b2", 32'(host_out_data), 32'hB2);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("eg_a1", 32'(host_out_data), 32'hA1);
    chk("eg_a1_busy", 32'(chunk_in_ready), 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("eg_done_valid", 32'(host_out_valid), 32'h0);
    chk("eg_done_ready", 32'(chunk_in_ready), 32'h1);

    // Push of a completed chunk and pop in the same cycle
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 5; i <= 7; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("pushpop_fill", 32'(fill_level), 32'h1);
    chk("pushpop_head", chunk_out, 32'h08070605);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);

    // Randomised traffic on both paths at once
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));

`ifdef CHUNK_STREAM_FLUSH_EN
    // Drain everything, then flush a two-byte partial chunk
    host_in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1);
    while (part.size() != 0) cyc(1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0, 32'h0, 1'b0);
    host_in_valid = 1'b0;
    host_flush    = 1'b1;
    #1;
    chk("flush_done", 32'(host_flush_done), 32'h1);
    @(posedge clk);
    host_flush = 1'b0;
    part.delete();
    cq.push_back(32'h00006655);
    #1;
    chk("flush_chunk", chunk_out, 32'h00006655);
    chk("flush_done_low", 32'(host_flush_done), 32'h0);
    check_all();
    for (int i = 0; i < NB; i++) cyc(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 32'h0, 1'b0);
    chk("post_flush_chunk", chunk_out, 32'h73727170);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chunk_stream_buffer.md
Name: chunk_stream_buffer

Overview:
- Parametrised successor to the single-chunk local-memory buffer. Bridges the byte-serial host port and the wide chunk port of the Matrix Processing Unit local memory, in both directions.
- Ingress: host bytes are packed into CHUNK_BITS-wide chunks and queued in a DEPTH-entry chunk FIFO for the datapath.
- Egress: one chunk from the datapath is unpacked into host bytes.
- All transfers use valid/ready handshakes. Nothing is dropped silently.

Parameters:
- CHUNK_BITS, 512, chunk width in bits. Multiple of 8, at least 16. BYTES = CHUNK_BITS/8.
- DEPTH, 4, ingress chunk FIFO entries. Power of 2, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_in_data  in  8  ingress byte.
- host_in_valid  in  1  ingress byte valid.
- host_in_ready  out  1  ingress byte accepted when valid&ready.
- chunk_out  out  CHUNK_BITS  FIFO head chunk; zero when FIFO empty.
- chunk_out_valid  out  1  FIFO non-empty.
- chunk_out_ready  in  1  datapath pops head on valid&ready.
- chunk_in  in  CHUNK_BITS  egress chunk.
- chunk_in_valid  in  1  egress chunk valid.
- chunk_in_ready  out  1  egress unpacker idle.
- host_out_data  out  8  egress byte.
- host_out_valid  out  1  egress byte valid.
- host_out_ready  in  1  host consumes byte on valid&ready.
- fill_level  out  $clog2(DEPTH+1)  chunks held in FIFO.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - byte counters, FIFO pointers and fill_level go to 0.
  - chunk_out_valid=0, host_out_valid=0, chunk_out=0, host_out_data=0.
  - host_in_ready=1, chunk_in_ready=1.
  - FIFO storage is not cleared.
  - Reset mid-operation discards any partial chunk and any in-progress unpack.
- Byte order:
  - Byte k of a chunk occupies bits [8k+7:8k].
  - The first byte transferred is byte 0, in both directions.
- Ingress packer:
  - Counter in_cnt runs 0..BYTES-1. Each accepted byte is stored at slot in_cnt, then in_cnt increments.
  - On the byte with in_cnt==BYTES-1, the full chunk (stored bytes plus the current byte) is written into the FIFO in the same edge and in_cnt wraps to 0.
  - host_in_ready = !(in_cnt==BYTES-1 && FIFO full). A pop in the same cycle does not lift this; the FIFO has no pass-through.
- FIFO:
  - Latency: a chunk appears on chunk_out/chunk_out_valid in the cycle after its last byte is accepted.
  - Push and pop in the same cycle are allowed at any fill level other than full. fill_level is then unchanged and order is preserved.
  - Pointers wrap modulo DEPTH. fill_level is 0..DEPTH.
  - Pop when empty is ignored.
- Egress unpacker, two states:
  - IDLE: chunk_in_ready=1. On chunk_in_valid, register chunk_in, set out_cnt=0, go to SEND.
  - SEND: host_out_valid=1, host_out_data = byte out_cnt. On host_out_ready, out_cnt increments.
  - On acceptance of byte BYTES-1, return to IDLE. host_out_valid drops on the next cycle and chunk_in_ready is high from that cycle.
  - So there is one bubble between chunks. host_out_data holds its value while valid is held and ready is low.
- Ingress and egress paths are fully independent and may operate in the same cycle.

Optional Feature:
- Macro CHUNK_STREAM_FLUSH_EN.
- With the macro defined:
  - Adds input host_flush (level request) and output host_flush_done (1-cycle pulse).
  - If in_cnt>0 and the FIFO is not full, the partial chunk is pushed with unfilled bytes zero. in_cnt goes to 0 and host_flush_done pulses in the same cycle.
  - If the FIFO is full, the request waits until space is available.
  - If in_cnt==0, host_flush_done pulses with no push.
  - If a byte is accepted in the same cycle, that byte is included in the flushed chunk. If that byte completes the chunk, a normal push occurs and done still pulses.
- Without the macro: the ports are absent, and chunks complete only on BYTES accepted bytes.

Decomposition:
- Package mpu_mem_pkg holds:
  - default CHUNK_BITS and DEPTH;
  - the BYTES derivation;
  - counter-width constants;
  - the egress state encoding (IDLE=0, SEND=1).
- Sub-module chunk_fifo: DEPTH x CHUNK_BITS storage with push/pop/full/empty/fill_level. The top level instantiates it for ingress.

Test Plan (CHUNK_BITS=32, DEPTH=2 unless noted):
- Assert rst mid-pack after bytes 0x11,0x22 -> all valids 0, fill_level=0, host_in_ready=1. Subsequent bytes 0xAA,0xBB,0xCC,0xDD -> chunk_out=0xDDCCBBAA, with no trace of 0x11/0x22.
- Bytes 0x11,0x22,0x33,0x44 -> cycle after the 4th accept: chunk_out=0x44332211, chunk_out_valid=1, fill_level=1.
- chunk_out_ready=0, write 2 chunks plus 3 bytes -> host_in_ready=0 while the 4th byte is presented. Pop one chunk -> host_in_ready=1 the next cycle, the 3rd chunk is queued, fill_level=2.
- chunk_in=0xA1B2C3D4 with host_out_ready toggling 1,0,1,1,1 -> host_out_data sequence D4,C3,B2,A1 with the stall holding C3. chunk_in_ready=0 until the cycle after A1 is accepted.
- fill_level=1, push the last byte and pop in the same cycle -> fill_level stays 1 and the new chunk follows the old one.
- (CHUNK_STREAM_FLUSH_EN) Bytes 0x55,0x66 then host_flush -> chunk_out=0x00006655, host_flush_done pulses once, in_cnt=0.
